// File: rtl/adder_pkg.sv
// adder_pkg: definitions shared by the serial arithmetic blocks.
//   state_e : control states of the digit-serial adder (IDLE, CALC, DONE).
//   clog2   : counter width for a count of n, never less than one bit.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // A one-value counter still needs a one-bit register.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: purely combinational DIGIT-bit ripple-carry adder.
//   a, b : DIGIT-bit addends
//   cin  : carry in
//   s    : DIGIT-bit sum
//   cout : carry out of the top bit
module adder_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    always_comb begin
        logic c;
        s = '0;
        c = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/serial_adder_n.sv
// serial_adder_n: digit-serial adder/subtractor, DIGIT bits per cycle, LSB first.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, sub sampled on accept)
//   a, b                 : WIDTH-bit operands
//   sub                  : 0 = a+b, 1 = a-b
//   out_valid / out_ready: result handshake
//   sum                  : WIDTH-bit result, modulo 2^WIDTH
//   carry                : unsigned carry out (for subtract, 1 = no borrow)
//   ovf                  : two's-complement overflow
//   busy                 : operation in progress or result pending
// Latency from accept to out_valid is WIDTH/DIGIT cycles.
module serial_adder_n
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf,
    output logic             busy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] slice_s;
    logic             slice_c;
    logic [WIDTH-1:0] sum_shift;

    adder_slice #(.DIGIT(DIGIT)) u_slice (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .cin  (c_q),
        .s    (slice_s),
        .cout (slice_c)
    );

    // New digit enters at the top; after N cycles the first digit has
    // reached the bottom and the sum is aligned.
    generate
        if (DIGIT == WIDTH) begin : g_full
            assign sum_shift = slice_s;
        end else begin : g_part
            assign sum_shift = {slice_s, sum_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    // Subtraction as a + ~b + 1: invert b, seed the carry with 1.
                    b_d     = sub ? ~b : b;
                    c_d     = sub;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                sum_d = sum_shift;
                c_d   = slice_c;
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    carry_d = slice_c;
                    // Operand sign bits sit at the top of the final digit.
                    ovf_d   = (a_q[DIGIT-1] == b_q[DIGIT-1]) &&
                              (slice_s[DIGIT-1] != a_q[DIGIT-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs decode registered state only.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
module tb_serial_adder_n;
    logic        clk;
    logic        rst;
    logic        in_valid, out_ready, sub;
    logic [15:0] a, b;
    logic        in_ready, out_valid, carry, ovf, busy;
    logic [15:0] sum;

    // index 0: WIDTH=8 DIGIT=1, index 1: WIDTH=8 DIGIT=8
    logic       in_valid8 [2];
    logic       out_ready8 [2];
    logic       sub8 [2];
    logic [7:0] a8 [2];
    logic [7:0] b8 [2];
    logic       in_ready8 [2];
    logic       out_valid8 [2];
    logic       carry8 [2];
    logic       ovf8 [2];
    logic       busy8 [2];
    logic [7:0] sum8 [2];

    int checks = 0;
    int failures = 0;

    serial_adder_n #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry), .ovf(ovf), .busy(busy)
    );

    serial_adder_n #(.WIDTH(8), .DIGIT(1)) dut_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid8[0]), .in_ready(in_ready8[0]),
        .a(a8[0]), .b(b8[0]), .sub(sub8[0]), .out_valid(out_valid8[0]), .out_ready(out_ready8[0]),
        .sum(sum8[0]), .carry(carry8[0]), .ovf(ovf8[0]), .busy(busy8[0])
    );

    serial_adder_n #(.WIDTH(8), .DIGIT(8)) dut_d8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8[1]), .in_ready(in_ready8[1]),
        .a(a8[1]), .b(b8[1]), .sub(sub8[1]), .out_valid(out_valid8[1]), .out_ready(out_ready8[1]),
        .sum(sum8[1]), .carry(carry8[1]), .ovf(ovf8[1]), .busy(busy8[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    // Returns {carry, ovf, sum[15:0]}.
    function automatic logic [17:0] ref_op(input int w, input logic [15:0] x, input logic [15:0] y,
                                           input logic s);
        longint m, half, ux, uy, sx, sy, full, res, r;
        logic c, o;
        m    = longint'(1) << w;
        half = m / 2;
        ux   = longint'(x) & (m - 1);
        uy   = longint'(y) & (m - 1);
        full = s ? (ux - uy) : (ux + uy);
        res  = ((full % m) + m) % m;
        c    = s ? (ux >= uy) : (full >= m);
        sx   = (ux >= half) ? ux - m : ux;
        sy   = (uy >= half) ? uy - m : uy;
        r    = s ? (sx - sy) : (sx + sy);
        o    = (r >= half) || (r < -half);
        return {c, o, res[15:0]};
    endfunction

    // One operation on the 16-bit DUT with out_ready high.
    // lat: edges from accept until out_valid seen; lows: samples with in_ready low.
    task automatic run16(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                         output int lat, output int lows,
                         output logic [15:0] rs, output logic rc, output logic ro);
        @(negedge clk);
        a = ta; b = tb; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1; lows = 0; rs = '0; rc = 1'b0; ro = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) break;
            lows++;
            if (out_valid && lat < 0) begin
                lat = i; rs = sum; rc = carry; ro = ovf;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if ({carry, ovf, sum} !== 18'h0) begin failures++; $display("FAIL reset_result got=%h want=0", {carry, ovf, sum}); end
        checks++; if ({in_ready8[0], in_ready8[1], out_valid8[0], out_valid8[1], busy8[0], busy8[1]} !== 6'b110000) begin
            failures++; $display("FAIL reset_sweep_duts got=%b want=110000",
                                 {in_ready8[0], in_ready8[1], out_valid8[0], out_valid8[1], busy8[0], busy8[1]});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [15:0] va [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0003, 16'h8000};
        logic [15:0] vb [5] = '{16'h4321, 16'h0001, 16'h0001, 16'h0005, 16'h0001};
        logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [17:0] ve [5] = '{{2'b00, 16'h5555}, {2'b10, 16'h0000}, {2'b01, 16'h8000},
                                {2'b00, 16'hFFFE}, {2'b11, 16'h7FFF}};
        int lat, lows;
        logic [15:0] rs;
        logic rc, ro;
        for (int i = 0; i < 5; i++) begin
            run16(va[i], vb[i], vs[i], lat, lows, rs, rc, ro);
            checks++; if ({rc, ro, rs} !== ve[i]) begin failures++;
                $display("FAIL directed_%0d result got={c=%b o=%b s=%h} want={c=%b o=%b s=%h}",
                         i, rc, ro, rs, ve[i][17], ve[i][16], ve[i][15:0]); end
            checks++; if (lat !== 4) begin failures++; $display("FAIL directed_%0d latency got=%0d want=4", i, lat); end
            checks++; if (lows !== 5) begin failures++; $display("FAIL directed_%0d in_ready_low got=%0d want=5", i, lows); end
        end
    endtask

    task automatic test_random16();
        int lat, lows;
        logic [15:0] rs, x, y;
        logic rc, ro, s;
        logic [17:0] e;
        for (int i = 0; i < 200; i++) begin
            x = 16'($urandom); y = 16'($urandom); s = 1'($urandom);
            e = ref_op(16, x, y, s);
            run16(x, y, s, lat, lows, rs, rc, ro);
            checks++; if ({rc, ro, rs} !== e) begin failures++;
                $display("FAIL random16 %h%s%h got={c=%b o=%b s=%h} want={c=%b o=%b s=%h}",
                         x, s ? "-" : "+", y, rc, ro, rs, e[17], e[16], e[15:0]); end
            checks++; if (lat !== 4) begin failures++; $display("FAIL random16_latency got=%0d want=4", lat); end
        end
    endtask

    task automatic test_backpressure();
        logic [17:0] e;
        int k;
        e = ref_op(16, 16'h7FFF, 16'h0001, 1'b0);
        @(negedge clk);
        a = 16'h7FFF; b = 16'h0001; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin @(posedge clk); #1; k++; end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid_timeout got=%b want=1", out_valid); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
            checks++; if ({carry, ovf, sum} !== e || in_ready !== 1'b0 || out_valid !== 1'b1) begin failures++;
                $display("FAIL bp_hold_%0d got={c=%b o=%b s=%h rdy=%b vld=%b} want={c=%b o=%b s=%h rdy=0 vld=1}",
                         i, carry, ovf, sum, in_ready, out_valid, e[17], e[16], e[15:0]); end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if ({in_ready, out_valid, busy} !== 3'b100) begin failures++;
            $display("FAIL bp_consume got={rdy=%b vld=%b busy=%b} want={1,0,0}", in_ready, out_valid, busy); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({out_valid, busy, carry, ovf, sum} !== {2'b00, e}) begin failures++;
            $display("FAIL bp_no_stale_op got={vld=%b busy=%b c=%b o=%b s=%h} want={0,0,%b,%b,%h}",
                     out_valid, busy, carry, ovf, sum, e[17], e[16], e[15:0]); end
    endtask

    task automatic test_reset_mid();
        int lat, lows;
        logic [15:0] rs;
        logic rc, ro;
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if ({in_ready, out_valid, busy, sum} !== {3'b100, 16'h0000}) begin failures++;
            $display("FAIL midreset got={rdy=%b vld=%b busy=%b s=%h} want={1,0,0,0000}", in_ready, out_valid, busy, sum); end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_no_result got=%b want=0", out_valid); end
        run16(16'h0001, 16'h0001, 1'b0, lat, lows, rs, rc, ro);
        checks++; if ({rc, ro, rs} !== 18'h00002) begin failures++;
            $display("FAIL midreset_after got={c=%b o=%b s=%h} want={0,0,0002}", rc, ro, rs); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL midreset_after_latency got=%0d want=4", lat); end
    endtask

    task automatic test_sweep(input int idx, input int lat_exp);
        logic [7:0] edge_v [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};
        logic [7:0] x, y;
        logic s;
        logic [17:0] e;
        int lat;
        logic [9:0] got;
        for (int i = 0; i < 1000; i++) begin
            x = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : 8'($urandom);
            y = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : 8'($urandom);
            s = 1'($urandom);
            e = ref_op(8, {8'h00, x}, {8'h00, y}, s);
            @(negedge clk);
            a8[idx] = x; b8[idx] = y; sub8[idx] = s; in_valid8[idx] = 1'b1; out_ready8[idx] = 1'b1;
            @(posedge clk); #1;
            in_valid8[idx] = 1'b0;
            lat = 0; got = '0;
            while (!out_valid8[idx] && lat < 30) begin @(posedge clk); #1; lat++; end
            got = {carry8[idx], ovf8[idx], sum8[idx]};
            checks++; if (got !== {e[17:16], e[7:0]}) begin failures++;
                $display("FAIL sweep%0d %h%s%h got={c=%b o=%b s=%h} want={c=%b o=%b s=%h}",
                         idx, x, s ? "-" : "+", y, got[9], got[8], got[7:0], e[17], e[16], e[7:0]); end
            checks++; if (lat !== lat_exp) begin failures++;
                $display("FAIL sweep%0d_latency got=%0d want=%0d", idx, lat, lat_exp); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0; a = '0; b = '0;
        for (int i = 0; i < 2; i++) begin
            in_valid8[i] = 1'b0; out_ready8[i] = 1'b1; sub8[i] = 1'b0; a8[i] = '0; b8[i] = '0;
        end
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random16();
        test_sweep(0, 8);
        test_sweep(1, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
